// File: rtl/pipe_ctrl.sv
// Pipeline stall controller: merges ID load-use requests with the EX multi-cycle mul/div timer.
// Optional stall-cycle counter is built when PIPE_STALL_CNT_EN is defined.
module pipe_ctrl #(
   parameter int unsigned MD_CNT_W = 6
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                stallreq_id,
   input  logic                md_start,
   input  logic [MD_CNT_W-1:0] md_len,
   output logic [5:0]          stall,
   output logic                md_ready,
   output logic                md_busy,
   output logic [31:0]         stall_cycles
);

   localparam logic [5:0] StallMd  = 6'b001111;
   localparam logic [5:0] StallLd  = 6'b000111;
   localparam logic [5:0] StallNone = 6'b000000;

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e              state_q, state_d;
   logic [MD_CNT_W-1:0] cnt_q, cnt_d;
   logic                single_cycle;

   // A length of 0 behaves like 1: the op finishes in its issue cycle.
   assign single_cycle = (md_len <= MD_CNT_W'(1));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      stall    = StallNone;
      md_ready = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (md_start) begin
               stall = StallMd;
               if (single_cycle) begin
                  md_ready = 1'b1;
               end else begin
                  cnt_d   = md_len - MD_CNT_W'(1);
                  state_d = StBusy;
               end
            end else if (stallreq_id) begin
               stall = StallLd;
            end
         end
         StBusy: begin
            stall = StallMd;
            cnt_d = cnt_q - MD_CNT_W'(1);
            if (cnt_q == MD_CNT_W'(1)) begin
               md_ready = 1'b1;
               state_d  = StIdle;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign md_busy = (state_q == StBusy);

`ifdef PIPE_STALL_CNT_EN
   logic [31:0] stall_cycles_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles_q <= '0;
      end else if (stall[0] && (stall_cycles_q != 32'hFFFF_FFFF)) begin
         stall_cycles_q <= stall_cycles_q + 32'd1;
      end
   end

   assign stall_cycles = stall_cycles_q;
`else
   assign stall_cycles = 32'h0;
`endif

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Central pipeline stall controller for the five-stage MIPS core. Merges the ID-stage load-use hazard request and the EX-stage multi-cycle multiply/divide occupancy into the per-stage `stall` bus consumed by PC, IF, ID, EX, MEM and WB. Owns the multi-cycle op timer: it holds the front of the pipeline and bubbles MEM until the op completes, then releases the pipeline.

## Interface
Parameters:
- `MD_CNT_W`, 6: width of the multi-cycle length field and internal down-counter.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  synchronous, active-high reset.
- `stallreq_id`  input  1  load-use hazard request from ID (`Stop`=1), level, valid the same cycle.
- `md_start`  input  1  one-cycle pulse: a mul/div instruction is in EX this cycle.
- `md_len`  input  `MD_CNT_W`  required EX occupancy in cycles; sampled only when `md_start`=1.
- `stall`  output  `StallBus` (6)  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1=`Stop`.
- `md_ready`  output  1  one-cycle pulse in the last EX-occupied cycle; EX commits the mul/div result on it.
- `md_busy`  output  1  1 while state is BUSY.
- `stall_cycles`  output  32  count of cycles with `stall[0]`=`Stop` (see Configuration).

## Operation
- States: IDLE, BUSY. Down-counter `cnt` (`MD_CNT_W` bits).
- Effective length `N` = `md_len`, with 0 treated as 1.
- IDLE, `md_start`=1, `N`=1: `stall`=6'b001111 this cycle, `md_ready`=1 this cycle, stay IDLE.
- IDLE, `md_start`=1, `N`>1: `stall`=6'b001111 this cycle, `cnt`<=N-1, go BUSY.
- IDLE, `md_start`=0, `stallreq_id`=1: `stall`=6'b000111 (PC/IF/ID held, bubble into EX).
- IDLE otherwise: `stall`=6'b000000.
- BUSY: `stall`=6'b001111 regardless of `stallreq_id`; `cnt`<=`cnt`-1 each cycle; when `cnt`=1, `md_ready`=1 and next state IDLE.
- `md_start` in BUSY is ignored (EX is held, so a legal upstream never raises it); `cnt` not reloaded.
- Simultaneous `md_start` and `stallreq_id` in IDLE: multi-cycle pattern wins (6'b001111 is a superset).
- Bubble rule relied on by stages: stall[k]=`Stop` with stall[k+1]=`NoStop` makes stage k+1 load a zero bus.
- `stall[5:4]` are always `NoStop`.

## Timing
- `stall` and `md_ready` are combinational from inputs, state and `cnt`; no registered latency on request-to-stall.
- mul/div with `md_start` at cycle T, length N: `stall`=6'b001111 for cycles T..T+N-1, `md_ready` at T+N-1, `stall` released at T+N.
- Load-use: `stall`=6'b000111 exactly while `stallreq_id`=1 in IDLE.
- Reset: state IDLE, `cnt`=0, `stall`=0, `md_ready`=0, `md_busy`=0, `stall_cycles`=0; reset during BUSY abandons the op with no `md_ready`.
- `md_busy` registered: high from T+1 to T+N-1 inclusive for N>1.

## Configuration
- `PIPE_STALL_CNT_EN` defined: `stall_cycles` increments by 1 on every rising edge where `stall[0]`=1 and `rst`=0, saturating at 32'hFFFF_FFFF.
- Undefined: counter logic omitted, `stall_cycles` tied to 32'h0; all other behaviour identical.

## Test plan
- Reset mid-op: `md_start`, `md_len`=8, `rst` at T+3 -> `stall`=0 at T+4, no `md_ready`, `md_busy`=0.
- Load-use: `stallreq_id`=1 for 1 cycle in IDLE -> `stall`=6'b000111 that cycle, 6'b000000 next.
- Divide: `md_start`, `md_len`=32 at T -> `stall`=6'b001111 T..T+31, `md_ready` only at T+31, `stall`=0 at T+32.
- Length edge: `md_len`=0 and `md_len`=1 -> one stall cycle, `md_ready` same cycle as `md_start`, `md_busy` never 1.
- Overlap: `stallreq_id`=1 throughout a `md_len`=4 op -> `stall`=6'b001111 for 4 cycles, then 6'b000111 while request persists.
- Counter (`PIPE_STALL_CNT_EN`): 3 load-use cycles + `md_len`=5 op -> `stall_cycles`=8; undefined -> 0.
